// File: rtl/sr04_range_controller.sv
// sr04_range_controller: HC-SR04 trigger/echo timing with divider-free cm conversion.
// Optional BTN_DEBOUNCE_EN adds a DEB_CYCLES stability filter on the start button.
`timescale 1ns/1ps
module sr04_range_controller #(
  parameter int TRIG_US      = 10,
  parameter int US_PER_CM    = 58,
  parameter int ECHO_WAIT_US = 30000,
  parameter int ECHO_MAX_US  = 38000,
  parameter int DEB_CYCLES   = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_r,
  input  logic        i_tick_1us,
  input  logic        echo,
  output logic        o_trigger,
  output logic [23:0] distance
);
  typedef enum logic [1:0] {IDLE, TRIG, WAIT_ECHO, MEASURE} state_t;
  state_t state, state_n;
  logic e_s1, e_s2, b_s1, b_s2, b_lvl, b_q, start;
  logic [15:0] cnt, cnt_n, cnt_inc, sub, sub_n, cm, cm_n;
  logic [23:0] dist_n;
  logic trig_n;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {e_s1, e_s2, b_s1, b_s2, b_q} <= '0;
    else {e_s1, e_s2, b_s1, b_s2, b_q} <= {echo, e_s1, btn_r, b_s1, b_lvl};
`ifdef BTN_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  logic [DW-1:0] deb_cnt;
  logic deb;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      deb_cnt <= '0;
      deb <= 1'b0;
    end else if (b_s2 == deb) deb_cnt <= '0;
    else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
      deb_cnt <= '0;
      deb <= b_s2;
    end else deb_cnt <= deb_cnt + 1'b1;
  assign b_lvl = deb;
`else
  assign b_lvl = b_s2;
`endif
  assign start = b_lvl & ~b_q;
  assign cnt_inc = cnt + 16'd1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      sub <= '0;
      cm <= '0;
      distance <= '0;
      o_trigger <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sub <= sub_n;
      cm <= cm_n;
      distance <= dist_n;
      o_trigger <= trig_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sub_n = sub;
    cm_n = cm;
    dist_n = distance;
    trig_n = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = TRIG;
        cnt_n = '0;
        trig_n = 1'b1;
      end
      TRIG: begin
        trig_n = 1'b1;
        if (i_tick_1us) begin
          cnt_n = cnt_inc;
          if (cnt_inc >= 16'(TRIG_US)) begin
            trig_n = 1'b0;
            cnt_n = '0;
            state_n = WAIT_ECHO;
          end
        end
      end
      WAIT_ECHO:
        if (e_s2) begin
          // a tick landing on the rising edge belongs to the echo width
          state_n = MEASURE;
          cnt_n = {15'd0, i_tick_1us};
          sub_n = {15'd0, i_tick_1us};
          cm_n = '0;
        end else if (i_tick_1us) begin
          cnt_n = cnt_inc;
          if (cnt_inc >= 16'(ECHO_WAIT_US)) begin
            dist_n = '0;
            state_n = IDLE;
          end
        end
      MEASURE:
        if (!e_s2) begin
          dist_n = {8'd0, cm};
          state_n = IDLE;
        end else if (i_tick_1us) begin
          cnt_n = cnt_inc;
          sub_n = (sub == 16'(US_PER_CM - 1)) ? 16'd0 : sub + 16'd1;
          cm_n = (sub == 16'(US_PER_CM - 1)) ? cm + 16'd1 : cm;
          if (cnt_inc >= 16'(ECHO_MAX_US)) begin
            dist_n = 24'hFFFFFF;
            state_n = IDLE;
          end
        end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sr04_range_controller.sv
// tb_sr04_range_controller: scoreboard bench; 1 us = 4 clk, timeouts scaled down to keep runs short.
`timescale 1ns/1ps
module tb_sr04_range_controller;
  localparam int DEB = 50;
`ifdef BTN_DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif
  logic clk = 0, rst = 0, btn_r = 0, tick = 0, echo = 0;
  logic o_trigger;
  logic [23:0] distance;
  int total = 0, bad = 0;
  int pulses = 0, tw = 0, ov = 0;
  logic trig_q = 0;
  int exp_q[$];
  sr04_range_controller #(
    .TRIG_US(10), .US_PER_CM(58), .ECHO_WAIT_US(3000), .ECHO_MAX_US(4000), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .btn_r(btn_r), .i_tick_1us(tick), .echo(echo),
    .o_trigger(o_trigger), .distance(distance)
  );
  always #5 clk = ~clk;
  initial forever begin
    repeat (3) @(negedge clk);
    tick = 1;
    @(negedge clk);
    tick = 0;
  end
  always @(posedge clk) begin
    trig_q <= o_trigger;
    if (o_trigger && !trig_q) pulses <= pulses + 1;
    if (o_trigger && tick) tw <= tw + 1;
    if (o_trigger && echo) ov <= ov + 1;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic us(input int n);
    repeat (n * 4) @(negedge clk);
  endtask
  task automatic press_wait(output int lat);
    btn_r = 1;
    lat = 0;
    while (!o_trigger && lat < LAT + 10) begin
      @(posedge clk);
      #1 lat++;
    end
    check("trig_lat", 32'(o_trigger && lat <= LAT), 1);
    @(negedge clk);
  endtask
  task automatic meas(input int w, input int exp, input bit poke);
    int p0, t0, o0, lat;
    exp_q.push_back(exp);
    p0 = pulses; t0 = tw; o0 = ov;
    press_wait(lat);
    us(100);
    btn_r = 0;
    us(115);
    echo = 1;
    if (poke) begin
      us(100);
      btn_r = 1;
      us(50);
      btn_r = 0;
      us(w - 150);
    end else us(w);
    echo = 0;
    repeat (3) @(posedge clk);
    #1 check("dist", 32'(distance), 32'(exp_q.pop_front()));
    check("pulses", pulses - p0, 1);
    check("trig_w", 32'(tw - t0 >= 9 && tw - t0 <= 11), 1);
    check("trig_in_echo", ov - o0, 0);
    us(20);
  endtask
  initial begin
    int p0, lat;
    #20 rst = 1;
    #1 check("rst_trig", 32'(o_trigger), 0);
    check("rst_dist", 32'(distance), 0);
    @(negedge clk);
    us(5);
    meas(580, 10, 0);
    meas(57, 0, 0);
    meas(58, 1, 0);
    meas(116, 2, 0);
    meas(115, 1, 0);
    exp_q.push_back(0);
    p0 = pulses;
    press_wait(lat);
    us(100);
    btn_r = 0;
    us(2800);
    check("wait_hold", 32'(distance), 1);
    us(400);
    check("wait_to", 32'(distance), 32'(exp_q.pop_front()));
    check("wait_pulses", pulses - p0, 1);
    meas(4100, 24'hFFFFFF, 0);
    meas(580, 10, 0);
    meas(1160, 20, 1);
`ifdef BTN_DEBOUNCE_EN
    p0 = pulses;
    btn_r = 1;
    us(5);
    btn_r = 0;
    us(50);
    check("glitch", pulses - p0, 0);
`endif
    press_wait(lat);
    us(2);
    #3 rst = 0;
    #1 check("abort_trig", 32'(o_trigger), 0);
    check("abort_dist", 32'(distance), 0);
    @(negedge clk);
    rst = 1;
    btn_r = 0;
    us(20);
    meas(580, 10, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
